signed_seg_driver: RTL and testbench

SIGNED_SEG_DRIVER -- requirements
Module: signed_seg_driver

---
 rtl/seg_pkg.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 75 +++++++
 rtl/signed_seg_driver.sv | 92 +++++++++
 tb/tb_signed_seg_driver.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Seven-segment glyph codes and converter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low
    localparam logic [7:0] c_seg_blank = 8'hFF;
    localparam logic [7:0] c_seg_minus = 8'hBF;
    localparam logic [7:0] c_seg_e     = 8'h86;
    localparam logic [7:0] c_seg_r     = 8'hAF;

    localparam logic [2:0] c_last_iter = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } conv_state_t;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = c_seg_blank;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble, 6-bit magnitude to tens/ones BCD.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [5:0] i_mag,
    output logic       o_done,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    conv_state_t r_state;
    logic [2:0]  r_iter;
    logic [13:0] r_sr;      // {tens, ones, binary}
    logic        r_done;
    logic [13:0] w_adj;

    always_comb begin
        w_adj = r_sr;
        if (r_sr[9:6] >= 4'd5)
            w_adj[9:6] = r_sr[9:6] + 4'd3;
        if (r_sr[13:10] >= 4'd5)
            w_adj[13:10] = r_sr[13:10] + 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_iter  <= 3'd0;
            r_sr    <= 14'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start)
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_sr    <= {8'd0, i_mag};
                    r_iter  <= 3'd0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_sr <= {w_adj[12:0], 1'b0};
                    if (r_iter == c_last_iter) begin
                        r_state <= COMMIT;
                        r_done  <= 1'b1;
                    end else begin
                        r_iter <= r_iter + 3'd1;
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_done = r_done;
    assign o_tens = r_sr[13:10];
    assign o_ones = r_sr[9:6];

endmodule
`default_nettype wire

// File: rtl/signed_seg_driver.sv
`default_nettype none
// ============================================================================
//  Module      : signed_seg_driver
//  Description : Multiplexed 4-digit display of a signed 6-bit ALU result.
//  Revision    : 1.0  initial release
// ============================================================================
module signed_seg_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 400_000
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic [5:0] value,
    input  logic       err,
    output logic [3:0] anodes,
    output logic [7:0] cathodes
);

    localparam int                 c_cnt_w    = $clog2(REFRESH_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_index;
    logic [3:0]         r_anodes;
    logic [5:0]         r_hold_value;
    logic               r_hold_err;
    logic [3:0][7:0]    r_glyph;

    logic               w_wrap;
    logic [1:0]         w_index_next;
    logic               w_sample;
    logic [5:0]         w_mag;
    logic               w_done;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;

    assign w_wrap       = (r_cnt == c_cnt_last);
    assign w_index_next = w_wrap ? r_index + 2'd1 : r_index;
    assign w_sample     = (r_cnt == '0) && (r_index == 2'd0);
    // Unsigned 6-bit negate maps -32 to 32 without loss
    assign w_mag        = r_hold_value[5] ? (6'd0 - r_hold_value) : r_hold_value;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_index      <= 2'd0;
            r_anodes     <= 4'b1111;
            r_hold_value <= 6'd0;
            r_hold_err   <= 1'b0;
        end else begin
            r_cnt    <= w_wrap ? '0 : r_cnt + 1'b1;
            r_index  <= w_index_next;
            r_anodes <= ~(4'b0001 << w_index_next);
            if (w_sample) begin
                r_hold_value <= value;
                r_hold_err   <= err;
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk     (clk_100MHz),
        .rst     (rst),
        .i_start (w_sample),
        .i_mag   (w_mag),
        .o_done  (w_done),
        .o_tens  (w_tens),
        .o_ones  (w_ones)
    );

    // Hold registers are stable for the whole conversion, so sign/err come from them
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_glyph <= {4{c_seg_blank}};
        end else if (w_done) begin
            if (r_hold_err) begin
                r_glyph <= {c_seg_blank, c_seg_e, c_seg_r, c_seg_r};
            end else begin
                r_glyph[3] <= r_hold_value[5] ? c_seg_minus : c_seg_blank;
                r_glyph[2] <= c_seg_blank;
                r_glyph[1] <= (w_tens == 4'd0) ? c_seg_blank : digit_glyph(w_tens);
                r_glyph[0] <= digit_glyph(w_ones);
            end
        end
    end

    assign anodes   = r_anodes;
    assign cathodes = r_glyph[r_index];

endmodule
`default_nettype wire

// File: tb/tb_signed_seg_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signed_seg_driver
//  Description : Directed self-checking bench for signed_seg_driver, REFRESH_DIV=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_signed_seg_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] value = 6'd0;
    logic       err = 1'b0;
    logic [3:0] anodes;
    logic [7:0] cathodes;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;    // rising edges since reset release

    signed_seg_driver #(.REFRESH_DIV(4)) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .value      (value),
        .err        (err),
        .anodes     (anodes),
        .cathodes   (cathodes)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target)
            check_val("sync_timeout", cyc, target);
    endtask

    task automatic check_frame(input string tag, input int start,
                               input logic [7:0] g3, input logic [7:0] g2,
                               input logic [7:0] g1, input logic [7:0] g0);
        logic [7:0] g [4];
        logic [3:0] exp_an;
        int idx;
        g = '{g0, g1, g2, g3};
        wait_cyc(start);
        for (int k = 0; k < 16; k++) begin
            idx    = (cyc / 4) % 4;
            exp_an = ~(4'b0001 << idx);
            check_val({tag, "_an"}, anodes, exp_an);
            check_val({tag, "_cat"}, cathodes, g[idx]);
            @(negedge clk);
        end
    endtask

    task automatic apply_and_check(input string tag, input logic [5:0] v, input logic e,
                                   input logic [7:0] g3, input logic [7:0] g2,
                                   input logic [7:0] g1, input logic [7:0] g0);
        int s;
        value = v;
        err   = e;
        s = ((cyc + 15) / 16) * 16;
        check_frame(tag, s + 9, g3, g2, g1, g0);
    endtask

    initial begin
        int s;
        value = 6'd5;
        err   = 1'b1;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_an", anodes, 4'b1111);
        check_val("rst_cat", cathodes, 8'hFF);

        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_an", anodes, 4'b1110);
        check_val("post_rst_cat", cathodes, 8'hFF);
        wait_cyc(8);
        check_val("pre_commit_cat", cathodes, 8'hFF);
        wait_cyc(9);
        check_val("latency_cat", cathodes, 8'h86);
        check_frame("err", 9, 8'hFF, 8'h86, 8'hAF, 8'hAF);

        // err drops mid-frame; old glyphs must persist until the next commit
        wait_cyc(25);
        err = 1'b0;
        check_frame("err_hold", 25, 8'hFF, 8'h86, 8'hAF, 8'hAF);
        check_frame("err_clear", 41, 8'hFF, 8'hFF, 8'hFF, 8'h92);

        apply_and_check("v19",  6'b010011, 1'b0, 8'hFF, 8'hFF, 8'hF9, 8'h90);
        apply_and_check("vm2",  6'b111110, 1'b0, 8'hBF, 8'hFF, 8'hFF, 8'hA4);
        apply_and_check("vm32", 6'b100000, 1'b0, 8'hBF, 8'hFF, 8'hB0, 8'hA4);
        apply_and_check("v0",   6'b000000, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        apply_and_check("v31",  6'b011111, 1'b0, 8'hFF, 8'hFF, 8'hB0, 8'hF9);

        // Reset while the converter is shifting a -2 sample
        value = 6'b111110;
        s = ((cyc + 15) / 16) * 16;
        wait_cyc(s + 3);
        value = 6'd7;
        rst   = 1'b1;
        #1;
        check_val("midrst_an", anodes, 4'b1111);
        check_val("midrst_cat", cathodes, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            wait_cyc(k);
            check_val("no_stale_cat", cathodes, 8'hFF);
        end
        check_frame("post_midrst", 9, 8'hFF, 8'hFF, 8'hFF, 8'hF8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
